// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: captures a frame of NWORDS words, shifts it MSB-first on a divided serial clock, then strobes a latch.
// Optional: define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_tx #(
  parameter int WORD_W  = 5,
  parameter int NWORDS  = 5,
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NWORDS*WORD_W-1:0]   din,
  input  logic                       start,
  output logic                       ser_clk,
  output logic                       ser_data,
  output logic                       ser_latch,
  output logic                       busy,
  output logic                       done
);

  localparam int N = NWORDS * WORD_W;
`ifdef PISO_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int BC_W = $clog2(NB + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_e;

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [BC_W-1:0] bitcnt_q, bitcnt_d;
  logic [NB-1:0]   shreg_q, shreg_d;
  logic            ser_clk_q, ser_clk_d;
  logic            ser_data_q, ser_data_d;
  logic            ser_latch_q, ser_latch_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_latch_q <= ser_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Outputs are decoded from the next-state values so they leave the flops aligned with the state.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef PISO_PARITY_EN
          shreg_d = {din, ^din};
`else
          shreg_d = din;
`endif
          phase_d  = '0;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d  = '0;
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BC_LAST) state_d = LATCH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ser_clk_d   = (state_d == SHIFT) && (phase_d >= PH_HALF);
    ser_data_d  = (state_d == SHIFT) && shreg_d[NB-1];
    ser_latch_d = (state_d == LATCH);
    busy_d      = (state_d == SHIFT) || (state_d == LATCH);
    done_d      = (state_d == DONE);
  end

  assign ser_clk   = ser_clk_q;
  assign ser_data  = ser_data_q;
  assign ser_latch = ser_latch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Randomized/directed bench for piso_tx; expected waveforms come from a cycle-index model of the frame timing.
module tb_piso_tx;

  localparam int N = 25;
`ifdef PISO_PARITY_EN
  localparam int NBT = N + 1;
`else
  localparam int NBT = N;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] dinA = '0, dinB = '0;
  logic startA = 1'b0, startB = 1'b0;
  logic sclkA, sdataA, slatchA, busyA, doneA;
  logic sclkB, sdataB, slatchB, busyB, doneB;
  int checks = 0;
  int errors = 0;
  logic qA[$];
  logic qB[$];

  always #5 clk = ~clk;

  piso_tx #(.WORD_W(5), .NWORDS(5), .CLK_DIV(2)) u_dutA (
    .clk(clk), .rst(rst), .din(dinA), .start(startA),
    .ser_clk(sclkA), .ser_data(sdataA), .ser_latch(slatchA), .busy(busyA), .done(doneA));

  piso_tx #(.WORD_W(5), .NWORDS(5), .CLK_DIV(1)) u_dutB (
    .clk(clk), .rst(rst), .din(dinB), .start(startB),
    .ser_clk(sclkB), .ser_data(sdataB), .ser_latch(slatchB), .busy(busyB), .done(doneB));

  // Receiver side: capture serial data on each rising serial clock.
  always @(posedge sclkA) if (rst) qA.push_back(sdataA);
  always @(posedge sclkB) if (rst) qB.push_back(sdataB);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expBit(input logic [N-1:0] d, input int k);
    if (k < N) return d[N-1-k];
    return ^d;
  endfunction

  // Expected {ser_clk, ser_data, ser_latch, busy, done} in cycle c after the accept edge.
  function automatic logic [4:0] expOut(input int h, input int c, input logic [N-1:0] d);
    logic sc, sd;
    if (c < 2*h*NBT) begin
      sc = 1'((c % (2*h)) >= h);
      sd = expBit(d, c / (2*h));
      return {sc, sd, 1'b0, 1'b1, 1'b0};
    end
    if (c < 2*h*(NBT+1)) return 5'b00110;
    if (c == 2*h*(NBT+1)) return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] obsOut(input int sel);
    if (sel == 1) return {sclkB, sdataB, slatchB, busyB, doneB};
    return {sclkA, sdataA, slatchA, busyA, doneA};
  endfunction

  task automatic setIn(input int sel, input logic s, input logic [N-1:0] d);
    if (sel == 1) begin startB = s; dinB = d; end
    else begin startA = s; dinA = d; end
  endtask

  task automatic applyStimulus(input int sel, input string tag, input logic [N-1:0] d,
                               input int startAt, input logic [N-1:0] d2,
                               input int abortAt, input bit startInDone);
    int h, doneC, lastC;
    logic rx [$];
    h = (sel == 1) ? 1 : 2;
    doneC = 2*h*(NBT+1);
    lastC = startInDone ? doneC + 1 : doneC + 2;
    qA.delete(); qB.delete();
    setIn(sel, 1'b1, d);
    @(posedge clk);
    for (int c = 0; c <= lastC; c++) begin
      @(negedge clk);
      if (c == 0) setIn(sel, 1'b0, d);
      chk($sformatf("%s_c%0d", tag, c), 32'(obsOut(sel)), 32'(expOut(h, c, d)));
      if (c == abortAt) begin
        #2 rst = 1'b0;
        #1 chk({tag, "_async_rstA"}, 32'(obsOut(0)), 32'd0);
        chk({tag, "_async_rstB"}, 32'(obsOut(1)), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (c == startAt) setIn(sel, 1'b1, d2);
      if (c == startAt + 1) setIn(sel, 1'b0, d2);
      if (startInDone && c == doneC) setIn(sel, 1'b1, d);
    end
    rx = (sel == 1) ? qB : qA;
    chk({tag, "_nedges"}, 32'(rx.size()), 32'(NBT));
    for (int k = 0; k < rx.size() && k < NBT; k++)
      chk($sformatf("%s_bit%0d", tag, k), 32'(rx[k]), 32'(expBit(d, k)));
  endtask

  task automatic checkOutput(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("%s_A%0d", tag, i), 32'(obsOut(0)), 32'd0);
      chk($sformatf("%s_B%0d", tag, i), 32'(obsOut(1)), 32'd0);
    end
  endtask

  initial begin
    logic [N-1:0] d, stream;
    // Reset held with start asserted: nothing may move.
    rst = 1'b0;
    setIn(0, 1'b1, N'($urandom));
    setIn(1, 1'b1, N'($urandom));
    checkOutput("rst_hold", 4);
    @(negedge clk);
    rst = 1'b1;
    setIn(0, 1'b0, '0);
    setIn(1, 1'b0, '0);
    checkOutput("rst_release", 3);

    // Words 1..5: also compare the captured stream to the literal pattern.
    d = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    applyStimulus(0, "words", d, -10, '0, -10, 1'b0);
    stream = '0;
    for (int k = 0; k < N && k < qA.size(); k++) stream[N-1-k] = qA[k];
    chk("words_stream", 32'(stream), 32'(25'b00001_00010_00011_00100_00101));

    // Start with new data while busy is ignored.
    applyStimulus(0, "busy_start", N'($urandom), 40, N'($urandom), -10, 1'b0);

    // Reset mid-frame, then a full zero frame.
    applyStimulus(0, "abort", N'($urandom), -10, '0, 37, 1'b0);
    checkOutput("post_abort", 2);
    applyStimulus(0, "zeros", '0, -10, '0, -10, 1'b0);

    // Fastest serial clock with all ones.
    applyStimulus(1, "div1_ones", '1, -10, '0, -10, 1'b0);

    // Parity-sensitive patterns (plain data bits when parity is off).
    applyStimulus(0, "ones", '1, -10, '0, -10, 1'b0);
    applyStimulus(0, "three", N'(3), -10, '0, -10, 1'b0);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, $sformatf("randA%0d", i), N'($urandom), -10, '0, -10, 1'b0);
      applyStimulus(1, $sformatf("randB%0d", i), N'($urandom), -10, '0, -10, 1'b0);
    end

    // Start held through DONE is taken one cycle later from IDLE.
    d = N'($urandom);
    applyStimulus(0, "done_start", d, -10, '0, -10, 1'b1);
    @(negedge clk);
    chk("done_start_accept", 32'(obsOut(0)), 32'({1'b0, d[N-1], 1'b0, 1'b1, 1'b0}));
    setIn(0, 1'b0, d);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("final_idle", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter. It is the driving end of the serial word chain that the SIPO test block deserializes. On `start` it captures NWORDS words of WORD_W bits each. It then shifts them out MSB-first on a generated serial clock, and finishes with a latch strobe so the receiver can transfer its shift register to its parallel outputs.

## Interface
- WORD_W, default 5: bits per word.
- NWORDS, default 5: words per frame; N = NWORDS*WORD_W serial bits.
- CLK_DIV, default 2: half-period H of `ser_clk` in `clk` cycles; must be ≥1.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  N  frame data; word 1 is in the MSBs, word 1 MSB is sent first.
- start  in  1  request; sampled only in IDLE.
- ser_clk  out  1  serial clock to the receiver; the receiver samples on its rising edge.
- ser_data  out  1  serial data; changes only while `ser_clk` is 0.
- ser_latch  out  1  end-of-frame strobe (receiver `out_sel`).
- busy  out  1  high from frame accept until the end of LATCH.
- done  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE
  - All outputs are 0.
  - `start`=1 at a rising edge loads `din` into the shift register, clears the counters, and moves to SHIFT.
- SHIFT
  - A phase counter runs 0..2H-1.
  - `ser_clk` = 0 for phases 0..H-1 and 1 for phases H..2H-1.
  - `ser_data` = shift-register MSB throughout.
  - At phase 2H-1 the register shifts left (0 fills in) and the bit counter increments.
  - After bit N-1 completes, the FSM moves to LATCH.
- LATCH
  - `ser_latch`=1, `ser_clk`=0, `ser_data`=0 for 2H cycles, then the FSM moves to DONE.
- DONE
  - One cycle with `done`=1 and `busy`=0, then IDLE.
  - `start` asserted during DONE is ignored; it is accepted from IDLE on the next cycle.
- `start` during SHIFT or LATCH is ignored; there is no queueing.
- `din` is sampled only at accept; changes during a frame have no effect.
- Counter widths: bit counter $clog2(N+1), phase counter $clog2(2H).
- Reset
  - Asserting `rst` low clears all state and outputs to 0 immediately, even mid-frame.
  - After release the FSM is in IDLE, and a new `start` begins a full frame.

## Timing
- Reset values: `ser_clk`=0, `ser_data`=0, `ser_latch`=0, `busy`=0, `done`=0; FSM = IDLE.
- Accept edge E0 (start=1 in IDLE):
  - From E0, `busy`=1 and `ser_data` = `din[N-1]`.
  - `ser_clk` rises at E0+H and falls at E0+2H.
  - Bit k is valid from E0+2Hk to E0+2H(k+1).
- `ser_latch` is high from E0+2HN to E0+2H(N+1).
- `done`=1 during the cycle starting at E0+2H(N+1); `busy` is 0 in that cycle.
- Defaults (N=25, H=2): 25 `ser_clk` rising edges, `ser_latch` high on cycles 100–103, `done` at cycle 104.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- PISO_PARITY_EN defined:
  - After the N data bits, one extra even-parity bit (XOR of all N captured bits) is sent with standard SHIFT timing.
  - The frame becomes N+1 bits, and LATCH/DONE shift by 2H cycles.
- PISO_PARITY_EN undefined: exactly N bits are sent, and no parity logic is generated.

## Test plan
- Reset: hold `rst`=0 with `start`=1 and random `din` → all outputs stay 0; release → still 0 until `start`.
- Frame with words {1,2,3,4,5}, defaults:
  - Required stream 00001_00010_00011_00100_00101, captured on `ser_clk` rising edges.
  - `ser_latch` high on cycles 100–103 after accept; `done` pulse at cycle 104; `busy` high on cycles 0–103.
- Start while busy:
  - Pulse `start` with new `din` at cycle 40 → ignored; the original frame is transmitted unchanged, with exactly one `done`.
- Reset mid-frame:
  - Drop `rst` at cycle 37 → all outputs 0 asynchronously.
  - After release, `start` with `din`=all-zeros → a full 25-bit zero frame and `done` at cycle 104.
- CLK_DIV=1, `din`=all-ones → 25 rising edges, `ser_data`=1 throughout SHIFT, `done` at cycle 52.
- PISO_PARITY_EN defined:
  - `din`=all-ones (25 ones) → 26th bit = 1, `done` at cycle 108.
  - `din`=0x0000003 → 26th bit = 0.
